serial_rx: RTL and testbench

//   Asynchronous 8N1 serial receiver for the PSX test harness. Samples the

---
 rtl/psx_serial_pkg.sv | 19 +
 rtl/sync_2ff.sv | 29 ++
 rtl/serial_rx.sv | 173 +++++++++++++++++
 tb/tb_serial_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/psx_serial_pkg.sv
// Shared constants for the PSX harness serial path: receiver state
// encoding, 8N1 frame shape and the default bit period at 48 MHz.
package psx_serial_pkg;

    // Receiver FSM encoding (kept as plain constants for legacy users)
    typedef logic [1:0] rx_state_t;

    localparam rx_state_t S_IDLE  = 2'd0;
    localparam rx_state_t S_START = 2'd1;
    localparam rx_state_t S_DATA  = 2'd2;
    localparam rx_state_t S_STOP  = 2'd3;

    // 8N1 framing: one start bit, eight data bits LSB first, one stop bit
    localparam int DATA_BITS = 8;

    // 48 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 416;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs. The reset value is a
// parameter so idle-high lines (serial RX) and idle-low probes can share it.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // First flop may go metastable; second flop gives it a cycle to settle
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver: oversamples the synchronised line, takes one sample
// per bit at mid-bit, emits one-cycle byte / framing-error strobes and an
// idle flag after a long mark period.
module serial_rx
    import psx_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int IDLE_BITS    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       strobe,
    output logic       idle,
    output logic       frame_err
);

    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W    = $clog2(DATA_BITS);
    localparam int IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_MAX);

    logic rx_s;

    rx_state_t              state_reg,    state_next;
    logic [CNT_W-1:0]       cnt_reg,      cnt_next;
    logic [IDX_W-1:0]       bit_idx_reg,  bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg,    shift_next;
    logic [DATA_BITS-1:0]   data_reg,     data_next;
    logic                   strobe_reg,   strobe_next;
    logic                   ferr_reg,     ferr_next;
    logic                   armed_reg,    armed_next;
    logic [IDLE_W-1:0]      idle_cnt_reg, idle_cnt_next;
    logic                   idle_reg,     idle_next;
    logic                   idle_clear;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame FSM: start-bit qualification, mid-bit data sampling, stop check.
    // armed_reg blocks a held-low line (break / bad stop) from being taken
    // as a new start bit until a mark has been seen.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        strobe_next  = 1'b0;
        ferr_next    = 1'b0;
        armed_next   = armed_reg;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next   = S_DATA;
                        bit_idx_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
                    bit_idx_next = bit_idx_reg + IDX_W'(1);
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = S_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                    armed_next = rx_s;
                    if (rx_s) begin
                        data_next   = shift_reg;
                        strobe_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Idle detector: saturating mark counter; the flag is sticky once the
    // count saturates and is also set by reset so a freshly reset link
    // reads as idle immediately.
    always_comb begin
        idle_clear    = (state_reg != S_IDLE) || !rx_s;
        idle_cnt_next = idle_cnt_reg;
        idle_next     = idle_reg;
        if (idle_clear) begin
            idle_cnt_next = '0;
            idle_next     = 1'b0;
        end else begin
            if (idle_cnt_reg != IDLE_SAT) begin
                idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
            end
            if (idle_cnt_next == IDLE_SAT) begin
                idle_next = 1'b1;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            strobe_reg   <= 1'b0;
            ferr_reg     <= 1'b0;
            armed_reg    <= 1'b1;
            idle_cnt_reg <= '0;
            idle_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            strobe_reg   <= strobe_next;
            ferr_reg     <= ferr_next;
            armed_reg    <= armed_next;
            idle_cnt_reg <= idle_cnt_next;
            idle_reg     <= idle_next;
        end
    end

    assign data      = data_reg;
    assign strobe    = strobe_reg;
    assign frame_err = ferr_reg;
    assign idle      = idle_reg;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx with a short bit period (16 clocks) and a
// 4-bit-time idle threshold (64 clocks).
module tb_serial_rx;
    import psx_serial_pkg::*;

    localparam int CPB      = 16;
    localparam int IB       = 4;
    localparam int IDLE_CYC = CPB * IB;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       strobe;
    logic       idle;
    logic       frame_err;

    serial_rx #(
        .CLKS_PER_BIT (CPB),
        .IDLE_BITS    (IB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .strobe    (strobe),
        .idle      (idle),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    int         strobe_cnt       = 0;
    int         ferr_cnt         = 0;
    int         last_strobe_cyc  = -1;
    int         idle_fall_cyc    = -1;
    int         idle_rise_cyc    = -1;
    logic [7:0] last_strobe_data = 8'h00;
    logic       idle_prev        = 1'b1;
    logic       both_bad         = 1'b0;
    logic       excl_bad         = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (strobe) begin
                strobe_cnt       <= strobe_cnt + 1;
                last_strobe_cyc  <= cyc;
                last_strobe_data <= data;
            end
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (strobe && idle) both_bad <= 1'b1;
            if (strobe && frame_err) excl_bad <= 1'b1;
            if (idle_prev && !idle) idle_fall_cyc <= cyc;
            if (!idle_prev && idle) idle_rise_cyc <= cyc;
        end
        idle_prev <= idle;
    end

    int last_start_cyc = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        last_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int s0;
        int f0;
        int t0;
        int cnt_bad;
        int lat;

        // Reset values
        rx    = 1'b1;
        reset = 1'b1;
        tick(3);
        check("rst_data",   32'(data),      32'h00);
        check("rst_strobe", 32'(strobe),    32'h0);
        check("rst_ferr",   32'(frame_err), 32'h0);
        check("rst_idle",   32'(idle),      32'h1);
        reset = 1'b0;

        // Test 4: mark for 64 cycles keeps idle high, then a byte
        cnt_bad = 0;
        for (int i = 0; i < IDLE_CYC; i++) begin
            tick(1);
            if (idle !== 1'b1) cnt_bad++;
        end
        check("t4_idle_hold", 32'(cnt_bad), 32'd0);
        send_frame(8'h3C, 1'b1);
        t0 = last_start_cyc;
        tick(80);
        check("t4_strobes", 32'(strobe_cnt), 32'd1);
        check("t4_data", 32'(last_strobe_data), 32'h3C);
        check("t4_idle_fall", 32'(idle_fall_cyc - t0 >= 1 && idle_fall_cyc - t0 <= 3), 32'd1);
        check("t4_idle_rise", 32'(idle_rise_cyc - last_strobe_cyc), 32'(IDLE_CYC));
        lat = last_strobe_cyc - t0;
        check("t4_latency", 32'(lat >= 154 && lat <= 156), 32'd1);

        // Test 1: 0x55 and 0xA3 back-to-back
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b1);
        check("t1_byte0", 32'(last_strobe_data), 32'h55);
        send_frame(8'hA3, 1'b1);
        check("t1_byte1", 32'(last_strobe_data), 32'hA3);
        check("t1_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
        tick(80);

        // Test 2: 3-cycle glitch on an idle line
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        t0 = cyc;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(12);
        check("t2_state", 32'(dut.state_reg), 32'(S_IDLE));
        check("t2_idle_low", 32'(idle), 32'd0);
        check("t2_idle_fall", 32'(idle_fall_cyc - t0 >= 1 && idle_fall_cyc - t0 <= 3), 32'd1);
        tick(80);
        check("t2_idle_back", 32'(idle), 32'd1);
        check("t2_strobes", 32'(strobe_cnt - s0), 32'd0);
        check("t2_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Test 3: 0x81 with a low stop bit
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        send_frame(8'h81, 1'b0);
        rx = 1'b1;
        tick(40);
        check("t3_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("t3_strobes", 32'(strobe_cnt - s0), 32'd0);
        check("t3_data_kept", 32'(data), 32'hA3);
        tick(80);

        // Test 5: reset in the middle of bit 4 of 0xFF, then 0x12
        s0 = strobe_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        tick(8);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("t5_idle_after_rst", 32'(idle), 32'd1);
        check("t5_data_after_rst", 32'(data), 32'h00);
        tick(5);
        for (int i = 5; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        tick(CPB);
        check("t5_no_strobe_ff", 32'(strobe_cnt - s0), 32'd0);
        send_frame(8'h12, 1'b1);
        tick(20);
        check("t5_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("t5_data", 32'(data), 32'h12);
        tick(80);

        // Test 6: 40 bit-time break, then 0x7E
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(4);
        cnt_bad = 0;
        for (int i = 0; i < 40 * CPB - 4; i++) begin
            tick(1);
            if (idle !== 1'b0) cnt_bad++;
        end
        check("t6_idle_low", 32'(cnt_bad), 32'd0);
        check("t6_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("t6_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        rx = 1'b1;
        tick(2 * CPB);
        send_frame(8'h7E, 1'b1);
        tick(20);
        check("t6_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("t6_data", 32'(data), 32'h7E);
        check("t6_ferr_total", 32'(ferr_cnt - f0), 32'd1);

        // Global exclusivity properties
        check("strobe_idle_excl", 32'(both_bad), 32'd0);
        check("strobe_ferr_excl", 32'(excl_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
